// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8-bit asynchronous serial receiver.
// Default frame is 8N1. Defining UART_RX_PARITY_EN adds an even parity bit
// between the last data bit and the stop bit (8E1).
// Every line decision is taken at the middle of a bit: the start bit is
// confirmed OVERSAMPLE/2 ticks after its falling edge, and each later bit
// is sampled OVERSAMPLE ticks after the previous sample point.
module uart_receiver #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_FULL  = OS_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
`endif

    state_e             state_q, state_d;
    logic               rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [2:0]         prime_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               dv_q, dv_d;
    logic               fe_q, fe_d;
    logic               tick, sample, fall;
`ifdef UART_RX_PARITY_EN
    logic               pe_q, pe_d;
    logic               par_bad_q, par_bad_d;
`endif

    // Synchronize the line, keep one older sample for edge detection, and
    // track when the pipeline holds real line samples rather than reset values.
    // NOTE: every flop uses non-blocking assignment so all registers update
    // from the same pre-edge values; blocking here would chain the stages
    // into one cycle and collapse the synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            prime_q    <= 3'b000;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            prime_q    <= {prime_q[1:0], 1'b1};
        end
    end

    // A start edge is only believed once the old sample came from the line
    // itself; a line held low through reset release cannot fake a 1->0 edge.
    assign fall   = prime_q[2] & rxd_prev_q & ~rxd_sync_q;
    assign tick   = (div_q == DIV_LAST);
    assign sample = tick && (os_cnt_q == OS_FULL);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic: divider, tick counter, bit sampling and frame checks.
    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);
        os_cnt_d  = tick ? os_cnt_q + OS_W'(1) : os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d      = 1'b0;
        par_bad_d = par_bad_q;
`endif

        case (state_q)
            IDLE: begin
                // Divider is parked at zero here, so a start edge restarts it.
                os_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && os_cnt_q == OS_HALF) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_d   = rxd_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    os_cnt_d  = '0;
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    os_cnt_d  = '0;
                    // Even parity: data plus parity bit must hold an even count of ones.
                    par_bad_d = ^{shift_q, rxd_sync_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    os_cnt_d = '0;
                    if (rxd_sync_q) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            pe_d = 1'b1;
                        end else begin
                            dv_d   = 1'b1;
                            data_d = shift_q;
                        end
`else
                        dv_d   = 1'b1;
                        data_d = shift_q;
`endif
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Stay out of IDLE while the line is held low (break).
                if (rxd_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data          = data_q;
    assign data_valid    = dv_q;
    assign framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`else
    assign parity_error  = 1'b0;
`endif
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; must be even and >= 8.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port data  output  8  last correctly received byte.
REQ-008 SHALL have port data_valid  output  1  one-clk pulse when data is updated.
REQ-009 SHALL have port framing_error  output  1  one-clk pulse on a bad stop bit.
REQ-010 SHALL have port parity_error  output  1  one-clk pulse on a parity mismatch; tied 0 when parity is compiled out.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass RxD through a 2-flop synchronizer, set to 1 on reset, before any use.
REQ-013 SHALL generate a one-clk tick every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks, integer division; the divider restarts on each start-bit detection.
REQ-014 SHALL use states IDLE, START, DATA, PARITY (present only with the macro), STOP and WAIT_IDLE.
REQ-015 IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-016 START: at tick OVERSAMPLE/2, line low -> DATA; line high -> IDLE, treated as a glitch with no outputs pulsed.
REQ-017 DATA SHALL sample 8 bits LSB first, each OVERSAMPLE ticks after the previous sample point (mid-bit), using a 3-bit bit counter that wraps 7->0 on exit.
REQ-018 After bit 7, the block SHALL enter PARITY if compiled in, else STOP.
REQ-019 STOP: mid-bit sample high -> data updated, data_valid pulses, then IDLE.
REQ-020 STOP: mid-bit sample low -> framing_error pulses, data is not updated, then WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL hold until the synchronized line is high (break condition), then go to IDLE.
REQ-022 data_valid, framing_error and parity_error SHALL assert exactly one clk after the stop-bit sample tick, never together, and never for longer than one clk.
REQ-023 data SHALL hold its value between valid frames.
REQ-024 A falling edge arriving in the half-bit after the stop sample SHALL be accepted as the next start bit, so back-to-back frames are supported with no idle gap.
REQ-025 Total latency from the start-bit falling edge on RxD to data_valid SHALL be 9.5 bit periods (10.5 with parity) plus 3 clk.

Reset
REQ-026 reset low SHALL immediately force state IDLE, with the divider, tick and bit counters at 0.
REQ-027 reset low SHALL immediately force data=8'h00, data_valid=0, framing_error=0, parity_error=0 and busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte with no pulse.
REQ-029 After reset release, the block SHALL require a fresh 1->0 transition before starting a frame.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: frame is start, 8 data bits, even parity bit, stop bit.
REQ-031 With UART_RX_PARITY_EN, a parity mismatch SHALL pulse parity_error, leave data unchanged, and still check the stop bit; a bad stop bit gives framing_error only.
REQ-032 Macro UART_RX_PARITY_EN undefined: frame is 8N1, the PARITY state is absent, and parity_error is constant 0.

Verification (CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, DIV=10)
REQ-033 8N1 frame 0xA5 -> data=8'hA5, one data_valid pulse, busy low afterwards.
REQ-034 Frames 0x00 then 0xFF with no idle gap -> two data_valid pulses; data=8'h00 then 8'hFF.
REQ-035 RxD low pulse of 3 ticks -> busy rises then falls; no pulse on any output; data unchanged.
REQ-036 Frame 0x3C with stop bit 0, line held low for 2 bit times -> one framing_error pulse; data keeps its old value; busy stays high until the line returns high.
REQ-037 reset pulsed low after bit 3 of a 0x5A frame -> all outputs 0 immediately; the next frame 0x81 is received correctly.
REQ-038 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> one parity_error pulse; the same frame with parity bit 1 -> data_valid with data=8'h07.
